// File: rtl/delivery_game_pkg.sv
// Shared definitions for the delivery game blocks:
// board geometry and the target picker state encoding.
package delivery_game_pkg;

   localparam int NUM_CELLS = 16;
   localparam int ADDR_W    = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ROLL  = 3'd1,
      CHECK = 3'd2,
      SCAN  = 3'd3,
      HOLD  = 3'd4,
      DONE  = 3'd5
   } state_t;

endpackage

// File: rtl/target_picker.sv
// Picks an undelivered cell as the next delivery target: random draws
// from the upstream LFSR first, then a linear scan as fallback.
module target_picker
   import delivery_game_pkg::*;
#(
   parameter int MAX_RETRIES = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              new_round,
   input  logic              request,
   input  logic              deliver,
   input  logic [ADDR_W-1:0] player_pos,
   input  logic [ADDR_W-1:0] rand_address,
   output logic              rand_enable,
   output logic [ADDR_W-1:0] target,
   output logic              target_valid,
   output logic              all_delivered,
   output logic [4:0]        delivered_count
);

   localparam logic [4:0] LP_MAX  = 5'(MAX_RETRIES);
   localparam logic [4:0] LP_FULL = 5'(NUM_CELLS);

   state_t               r_state;
   state_t               w_next;
   logic [NUM_CELLS-1:0] r_mask;
   logic [ADDR_W-1:0]    r_target;
   logic [ADDR_W-1:0]    r_ptr;
   logic [3:0]           r_retry;
   logic [4:0]           r_count;
   logic                 r_all;

   logic                 w_full;
   logic                 w_accept;
   logic                 w_scan_hit;
   logic [4:0]           w_retry_inc;
   logic                 w_retry_out;
   logic [4:0]           w_count_inc;

   assign w_full      = &r_mask;
   assign w_accept    = !r_mask[rand_address] &&
                        (rand_address != player_pos);
   assign w_scan_hit  = !r_mask[r_ptr];
   assign w_retry_inc = {1'b0, r_retry} + 5'd1;
   assign w_retry_out = (w_retry_inc >= LP_MAX);
   assign w_count_inc = r_count + 5'd1;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      rand_enable  = 1'b0;
      target_valid = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_full)       w_next = DONE;
            else if (request) w_next = ROLL;
         end
         ROLL: begin
            rand_enable = 1'b1;
            w_next      = CHECK;
         end
         CHECK: begin
            if (w_accept)         w_next = HOLD;
            else if (w_retry_out) w_next = SCAN;
            else                  w_next = ROLL;
         end
         SCAN: begin
            if (w_scan_hit) w_next = HOLD;
         end
         HOLD: begin
            target_valid = 1'b1;
            if (deliver) w_next = IDLE;
         end
         DONE: begin
            w_next = DONE;
         end
         default: w_next = IDLE;
      endcase
      // A new round overrides whatever the current state would do.
      if (new_round) w_next = IDLE;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_mask   <= '0;
         r_target <= '0;
         r_ptr    <= '0;
         r_retry  <= '0;
         r_count  <= '0;
         r_all    <= 1'b0;
      end else if (new_round) begin
         r_mask  <= '0;
         r_count <= '0;
         r_all   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_full && request) r_retry <= '0;
            end
            CHECK: begin
               if (w_accept) begin
                  r_target <= rand_address;
               end else begin
                  r_retry <= w_retry_inc[3:0];
                  if (w_retry_out) r_ptr <= rand_address;
               end
            end
            SCAN: begin
               if (w_scan_hit) r_target <= r_ptr;
               else            r_ptr    <= r_ptr + 4'd1;
            end
            HOLD: begin
               // Target is never a delivered cell, so count stays <= 16.
               if (deliver && !r_mask[r_target]) begin
                  r_mask[r_target] <= 1'b1;
                  r_count          <= w_count_inc;
                  r_all            <= (w_count_inc == LP_FULL);
               end
            end
            default: ;
         endcase
      end
   end

   assign target          = r_target;
   assign all_delivered   = r_all;
   assign delivered_count = r_count;

endmodule

// File: tb/tb_target_picker.sv
// Directed bench for target_picker: vector table for the basic
// draw/deliver flow plus sequences for retries, scan, done and reset.
module tb_target_picker;

   logic       clock = 1'b0;
   logic       reset;
   logic       new_round;
   logic       request;
   logic       deliver;
   logic [3:0] player_pos;
   logic [3:0] rand_address;
   logic       rand_enable;
   logic [3:0] target;
   logic       target_valid;
   logic       all_delivered;
   logic [4:0] delivered_count;

   int checks   = 0;
   int failures = 0;

   target_picker #(.MAX_RETRIES(8)) dut (
      .clock           (clock),
      .reset           (reset),
      .new_round       (new_round),
      .request         (request),
      .deliver         (deliver),
      .player_pos      (player_pos),
      .rand_address    (rand_address),
      .rand_enable     (rand_enable),
      .target          (target),
      .target_valid    (target_valid),
      .all_delivered   (all_delivered),
      .delivered_count (delivered_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       nr;
      logic       req;
      logic       dlv;
      logic [3:0] pp;
      logic [3:0] ra;
      logic       e_en;
      logic       e_tv;
      logic [3:0] e_tgt;
      logic [4:0] e_cnt;
      logic       e_all;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic en,
                             input logic tv, input logic [3:0] tgt,
                             input logic [4:0] cnt, input logic all);
      check({tag, ".rand_enable"}, int'(rand_enable), int'(en));
      check({tag, ".target_valid"}, int'(target_valid), int'(tv));
      check({tag, ".target"}, int'(target), int'(tgt));
      check({tag, ".count"}, int'(delivered_count), int'(cnt));
      check({tag, ".all"}, int'(all_delivered), int'(all));
   endtask

   // Pulse request, then run until target_valid; report rolls and edges.
   task automatic run_request(output int rolls, output int cyc,
                              output bit ok);
      rolls = 0;
      cyc   = 0;
      ok    = 1'b0;
      request = 1'b1;
      for (int i = 0; i < 200; i++) begin
         step();
         request = 1'b0;
         cyc++;
         if (rand_enable) rolls++;
         if (target_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("hold_reached", int'(ok), 1);
   endtask

   task automatic deliver_cell(input logic [3:0] a);
      int r, c;
      bit ok;
      rand_address = a;
      player_pos   = 4'd15 - a;
      run_request(r, c, ok);
      check("fill_target", int'(target), int'(a));
      deliver = 1'b1;
      step();
      deliver = 1'b0;
   endtask

   task automatic set_v(input int i, input logic nr, input logic req,
                        input logic dlv, input logic [3:0] pp,
                        input logic [3:0] ra, input logic e_en,
                        input logic e_tv, input logic [3:0] e_tgt,
                        input logic [4:0] e_cnt, input logic e_all);
      vecs[i] = '{nr, req, dlv, pp, ra, e_en, e_tv, e_tgt, e_cnt, e_all};
   endtask

   initial begin
      int  rolls, cyc;
      bit  ok;
      string tag;

      //     i  nr req dlv pp ra  en tv tgt cnt all
      set_v(0,  0, 1, 0, 0, 5,  1, 0, 0, 0, 0);
      set_v(1,  0, 0, 0, 0, 5,  0, 0, 0, 0, 0);
      set_v(2,  0, 0, 0, 0, 5,  0, 1, 5, 0, 0);
      set_v(3,  0, 1, 0, 0, 5,  0, 1, 5, 0, 0);
      set_v(4,  0, 0, 1, 0, 5,  0, 0, 5, 1, 0);
      set_v(5,  0, 0, 1, 0, 5,  0, 0, 5, 1, 0);
      set_v(6,  0, 1, 0, 0, 5,  1, 0, 5, 1, 0);
      set_v(7,  0, 0, 0, 0, 5,  0, 0, 5, 1, 0);
      set_v(8,  0, 0, 0, 0, 5,  1, 0, 5, 1, 0);
      set_v(9,  0, 0, 0, 0, 9,  0, 0, 5, 1, 0);
      set_v(10, 0, 0, 0, 0, 9,  0, 1, 9, 1, 0);
      set_v(11, 0, 0, 1, 0, 9,  0, 0, 9, 2, 0);
      set_v(12, 0, 1, 0, 7, 7,  1, 0, 9, 2, 0);
      set_v(13, 0, 0, 0, 7, 7,  0, 0, 9, 2, 0);
      set_v(14, 0, 0, 0, 7, 7,  1, 0, 9, 2, 0);
      set_v(15, 0, 0, 0, 7, 6,  0, 0, 9, 2, 0);
      set_v(16, 0, 0, 0, 7, 6,  0, 1, 6, 2, 0);
      set_v(17, 1, 0, 1, 7, 6,  0, 0, 6, 0, 0);

      reset = 1'b1;
      new_round = 1'b0;
      request = 1'b0;
      deliver = 1'b0;
      player_pos = 4'd0;
      rand_address = 4'd0;
      step();
      step();
      check_outs("reset", 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         new_round    = vecs[i].nr;
         request      = vecs[i].req;
         deliver      = vecs[i].dlv;
         player_pos   = vecs[i].pp;
         rand_address = vecs[i].ra;
         step();
         tag = $sformatf("vec%0d", i);
         check_outs(tag, vecs[i].e_en, vecs[i].e_tv, vecs[i].e_tgt,
                    vecs[i].e_cnt, vecs[i].e_all);
      end
      new_round = 1'b0;
      deliver   = 1'b0;
      request   = 1'b0;
      step();

      // Draws stuck on the player cell: 8 rolls, then scan from 3.
      player_pos   = 4'd3;
      rand_address = 4'd3;
      run_request(rolls, cyc, ok);
      check("stuck_rolls", rolls, 8);
      check("stuck_latency", cyc, 18);
      check("stuck_target", int'(target), 3);
      deliver = 1'b1;
      step();
      deliver = 1'b0;
      check("stuck_count", int'(delivered_count), 1);

      // Fill cells 0..14, then scan wraps to 15.
      new_round = 1'b1;
      step();
      new_round = 1'b0;
      check("nr_count", int'(delivered_count), 0);
      for (int a = 0; a < 15; a++) deliver_cell(4'(a));
      check("fill_count", int'(delivered_count), 15);
      check("fill_all", int'(all_delivered), 0);
      player_pos   = 4'd0;
      rand_address = 4'd2;
      run_request(rolls, cyc, ok);
      check("wrap_rolls", rolls, 8);
      check("wrap_latency", cyc, 31);
      check("wrap_target", int'(target), 15);
      deliver = 1'b1;
      step();
      deliver = 1'b0;
      check("last_count", int'(delivered_count), 16);
      check("last_all", int'(all_delivered), 1);
      check("last_tv", int'(target_valid), 0);
      request = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check("done_en", int'(rand_enable), 0);
         check("done_tv", int'(target_valid), 0);
         check("done_all", int'(all_delivered), 1);
      end
      request = 1'b0;
      new_round = 1'b1;
      step();
      new_round = 1'b0;
      check("done_nr_all", int'(all_delivered), 0);
      check("done_nr_count", int'(delivered_count), 0);
      check("done_nr_tv", int'(target_valid), 0);

      // Reset in the middle of a scan.
      deliver_cell(4'd4);
      check("pre_rst_count", int'(delivered_count), 1);
      player_pos   = 4'd0;
      rand_address = 4'd4;
      request = 1'b1;
      for (int i = 0; i < 17; i++) begin
         step();
         request = 1'b0;
      end
      check("scan_tv", int'(target_valid), 0);
      check("scan_en", int'(rand_enable), 0);
      reset = 1'b1;
      new_round = 1'b1;
      request = 1'b1;
      deliver = 1'b1;
      step();
      check_outs("mid_scan_rst", 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
      reset = 1'b0;
      new_round = 1'b0;
      request = 1'b0;
      deliver = 1'b0;
      step();
      check("post_rst_en", int'(rand_enable), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
